// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state encoding, parity-type
//                constants and the minimum bit period used by both the
//                transmit serializer and the receive sampler.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // FSM state encoding, explicit 3-bit width
    typedef logic [2:0] uart_state_t;

    localparam uart_state_t c_ST_IDLE   = 3'd0;
    localparam uart_state_t c_ST_START  = 3'd1;
    localparam uart_state_t c_ST_DATA   = 3'd2;
    localparam uart_state_t c_ST_PARITY = 3'd3;
    localparam uart_state_t c_ST_STOP   = 3'd4;

    // Parity type selector values
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // A bit period shorter than two clocks leaves no room for the edge
    // counter to wrap, so smaller requests are raised to this value.
    localparam logic [5:0] PRESCALE_MIN = 6'd2;

    function automatic logic [5:0] clamp_prescale(input logic [5:0] prescale);
        return (prescale < PRESCALE_MIN) ? PRESCALE_MIN : prescale;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Bit-period edge counter. While run is high the counter
//                steps 0..prescale-1 and bit_done strobes on the final
//                count, wrapping the counter to zero on the same edge.
//  Ports       : clk, rst (async, active-high), run, prescale[5:0]
//                -> edge_cnt[5:0], bit_done
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] prescale,
    output logic [5:0] edge_cnt,
    output logic       bit_done
);

    logic [5:0] r_edge_cnt;
    logic       w_bit_done;

    // Comparison is kept in 6 bits; prescale is already clamped to >= 2
    assign w_bit_done = run && (r_edge_cnt == (prescale - 6'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_cnt <= 6'd0;
        end else if (!run || w_bit_done) begin
            r_edge_cnt <= 6'd0;
        end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
        end
    end

    assign edge_cnt = r_edge_cnt;
    assign bit_done = w_bit_done;

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame_serializer
//  Description : UART transmit serializer. Accepts a parallel word in IDLE
//                and emits start, DATA_WIDTH data bits (LSB first), optional
//                parity and one stop bit, each held for Prescale clocks.
//  Ports       : clk, rst (async, active-high)
//                P_DATA[DATA_WIDTH-1:0], Data_Valid, PAR_EN, PAR_TYP,
//                Prescale[5:0] -> TX_OUT (idle high), Busy (both registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] c_LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_state_t           r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par;
    logic [5:0]            r_prescale;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_tx;
    logic                  r_busy;

    logic                  w_run;
    logic                  w_bit_done;
    logic                  w_parity;
    logic [BW-1:0]         w_bit_nxt;
    logic [5:0]            w_edge_cnt_unused;

    assign w_run     = (r_state != c_ST_IDLE);
    assign w_parity  = (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
    assign w_bit_nxt = r_bit_cnt + 1'b1;

    // The edge count itself is only exposed for debug visibility
    uart_bit_timer u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (w_run),
        .prescale (r_prescale),
        .edge_cnt (w_edge_cnt_unused),
        .bit_done (w_bit_done)
    );

    // Next line level is decided together with the state so that TX_OUT
    // always comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par      <= 1'b0;
            r_prescale <= PRESCALE_MIN;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (Data_Valid) begin
                        r_data     <= P_DATA;
                        r_par_en   <= PAR_EN;
                        r_par      <= w_parity;
                        r_prescale <= clamp_prescale(Prescale);
                        r_bit_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_bit_done) begin
                        r_tx      <= r_data[0];
                        r_bit_cnt <= '0;
                        r_state   <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            if (r_par_en) begin
                                r_tx    <= r_par;
                                r_state <= c_ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= c_ST_STOP;
                            end
                        end else begin
                            r_tx      <= r_data[w_bit_nxt];
                            r_bit_cnt <= w_bit_nxt;
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_bit_done) begin
                        r_tx    <= 1'b1;
                        r_state <= c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_done) begin
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_frame_serializer
//  Description : Directed self-checking bench for uart_tx_frame_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int n_vec;
    int n_err;

    uart_tx_frame_serializer #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level of bit slot idx of a frame: start, 8 data LSB first,
    // optional parity, stop.
    function automatic logic exp_line(input logic [7:0] d, input logic pe,
                                      input logic pb, input int idx);
        if (idx == 0)      return 1'b0;
        else if (idx <= 8) return d[idx-1];
        else if (idx == 9) return pe ? pb : 1'b1;
        else               return 1'b1;
    endfunction

    // Presents one request on a falling edge; returns on the falling edge
    // of the cycle where the start bit should be on the line.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [5:0] ps);
        @(negedge clk);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt; Prescale = 6'd3;
    endtask

    task automatic test_reset();
        rst = 1'b1; Data_Valid = 1'b0; P_DATA = 8'h00;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
        #1;
        n_vec++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: TX_OUT=%b Busy=%b, required 1/0", TX_OUT, Busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: TX_OUT=%b Busy=%b, required 1/0", TX_OUT, Busy);
        end
    endtask

    task automatic test_frame_a5();
        int bad = 0;
        send(8'hA5, 1'b0, 1'b0, 6'd8);
        for (int c = 0; c < 80; c++) begin
            n_vec++;
            if (TX_OUT !== exp_line(8'hA5, 1'b0, 1'b0, c / 8) || Busy !== 1'b1) begin
                n_err++; bad++;
                if (bad < 5)
                    $display("FAIL frame_a5 cyc %0d: TX_OUT=%b Busy=%b, required %b/1",
                             c, TX_OUT, Busy, exp_line(8'hA5, 1'b0, 1'b0, c / 8));
            end
            @(negedge clk);
        end
        n_vec++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL frame_a5_end: TX_OUT=%b Busy=%b, required 1/0", TX_OUT, Busy);
        end
    endtask

    task automatic test_parity(input logic pt, input logic pbit, input string name);
        int bad = 0;
        send(8'h03, 1'b1, pt, 6'd16);
        for (int c = 0; c < 176; c++) begin
            n_vec++;
            if (TX_OUT !== exp_line(8'h03, 1'b1, pbit, c / 16) || Busy !== 1'b1) begin
                n_err++; bad++;
                if (bad < 5)
                    $display("FAIL %s cyc %0d: TX_OUT=%b Busy=%b, required %b/1",
                             name, c, TX_OUT, Busy, exp_line(8'h03, 1'b1, pbit, c / 16));
            end
            @(negedge clk);
        end
        n_vec++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_end: TX_OUT=%b Busy=%b, required 1/0", name, TX_OUT, Busy);
        end
    endtask

    task automatic test_busy_ignore();
        int bad = 0;
        send(8'h00, 1'b0, 1'b0, 6'd8);
        for (int c = 0; c < 80; c++) begin
            n_vec++;
            if (TX_OUT !== exp_line(8'h00, 1'b0, 1'b0, c / 8) || Busy !== 1'b1) begin
                n_err++; bad++;
                if (bad < 5)
                    $display("FAIL busy_ignore cyc %0d: TX_OUT=%b Busy=%b, required %b/1",
                             c, TX_OUT, Busy, exp_line(8'h00, 1'b0, 1'b0, c / 8));
            end
            if (c == 30) begin
                P_DATA = 8'hFF; Data_Valid = 1'b1;
            end else begin
                Data_Valid = 1'b0;
            end
            @(negedge clk);
        end
        for (int c = 0; c < 20; c++) begin
            n_vec++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_err++;
                $display("FAIL busy_ignore_idle cyc %0d: TX_OUT=%b Busy=%b, required 1/0",
                         c, TX_OUT, Busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        @(negedge clk);
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd32;
        Data_Valid = 1'b1;
        @(negedge clk);
        P_DATA = 8'hAA;   // held request now carries the second byte
        for (int c = 0; c < 320; c++) begin
            n_vec++;
            if (TX_OUT !== exp_line(8'h55, 1'b0, 1'b0, c / 32) || Busy !== 1'b1) begin
                n_err++; bad++;
                if (bad < 5)
                    $display("FAIL b2b_first cyc %0d: TX_OUT=%b Busy=%b, required %b/1",
                             c, TX_OUT, Busy, exp_line(8'h55, 1'b0, 1'b0, c / 32));
            end
            @(negedge clk);
        end
        n_vec++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: TX_OUT=%b Busy=%b, required 1/0", TX_OUT, Busy);
        end
        @(negedge clk);
        Data_Valid = 1'b0;
        for (int c = 0; c < 320; c++) begin
            n_vec++;
            if (TX_OUT !== exp_line(8'hAA, 1'b0, 1'b0, c / 32) || Busy !== 1'b1) begin
                n_err++; bad++;
                if (bad < 10)
                    $display("FAIL b2b_second cyc %0d: TX_OUT=%b Busy=%b, required %b/1",
                             c, TX_OUT, Busy, exp_line(8'hAA, 1'b0, 1'b0, c / 32));
            end
            @(negedge clk);
        end
        n_vec++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: TX_OUT=%b Busy=%b, required 1/0", TX_OUT, Busy);
        end
    endtask

    task automatic test_prescale_min();
        int bad = 0;
        send(8'h0F, 1'b0, 1'b0, 6'd1);
        for (int c = 0; c < 20; c++) begin
            n_vec++;
            if (TX_OUT !== exp_line(8'h0F, 1'b0, 1'b0, c / 2) || Busy !== 1'b1) begin
                n_err++; bad++;
                if (bad < 5)
                    $display("FAIL prescale_min cyc %0d: TX_OUT=%b Busy=%b, required %b/1",
                             c, TX_OUT, Busy, exp_line(8'h0F, 1'b0, 1'b0, c / 2));
            end
            @(negedge clk);
        end
        n_vec++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL prescale_min_end: TX_OUT=%b Busy=%b, required 1/0", TX_OUT, Busy);
        end
    endtask

    task automatic test_reset_midframe();
        send(8'hA5, 1'b0, 1'b0, 6'd8);
        repeat (20) @(negedge clk);   // inside data bit 1 (line low)
        n_vec++;
        if (TX_OUT !== 1'b0 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_pre: TX_OUT=%b Busy=%b, required 0/1", TX_OUT, Busy);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_abort: TX_OUT=%b Busy=%b, required 1/0", TX_OUT, Busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            n_vec++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_quiet cyc %0d: TX_OUT=%b Busy=%b, required 1/0",
                         c, TX_OUT, Busy);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_frame_a5();
        test_parity(1'b0, 1'b0, "parity_even");
        test_parity(1'b1, 1'b1, "parity_odd");
        test_busy_ignore();
        test_back_to_back();
        test_prescale_min();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
